// File: rtl/ts_rx_analyzer_pkg.sv
// Shared constants for the TS receive analyzer: ordered-set symbols, type codes,
// symbol offsets, FSM encodings and the captured-field record.
package ts_rx_analyzer_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam logic [1:0] TS_NONE  = 2'd0;
  localparam logic [1:0] TS_TYPE1 = 2'd1;
  localparam logic [1:0] TS_TYPE2 = 2'd2;

  localparam int SYM_COM      = 0;
  localparam int SYM_LINK     = 1;
  localparam int SYM_LANE     = 2;
  localparam int SYM_NFTS     = 3;
  localparam int SYM_RATE     = 4;
  localparam int SYM_CTRL     = 5;
  localparam int SYM_ID_FIRST = 6;
  localparam int SYM_ID_LAST  = 15;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  typedef struct packed {
    logic [1:0] ts_type;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] ctrl;
  } ts_fields_t;

  function automatic logic [7:0] sym_of(input logic [127:0] ts, input int k);
    return ts[8*k +: 8];
  endfunction

endpackage

// File: rtl/ts_rx_analyzer_ts_decode.sv
// Combinational TS decode: extracts link/lane/N_FTS/rate/control symbols and
// classifies the ordered set as TS1, TS2 or malformed.
module ts_decode
  import ts_rx_analyzer_pkg::*;
(
  input  logic [127:0] ts,
  output logic         well_formed,
  output logic [1:0]   ts_type,
  output logic [7:0]   link,
  output logic [7:0]   lane,
  output logic [7:0]   nfts,
  output logic [7:0]   rate,
  output logic [7:0]   ctrl
);

  localparam int ID_N = SYM_ID_LAST - SYM_ID_FIRST + 1;

  logic [ID_N-1:0] ts1_hit;
  logic [ID_N-1:0] ts2_hit;
  logic            com_ok;

  genvar gi;
  generate
    for (gi = SYM_ID_FIRST; gi <= SYM_ID_LAST; gi++) begin : g_id
      assign ts1_hit[gi-SYM_ID_FIRST] = (sym_of(ts, gi) == TS1_ID);
      assign ts2_hit[gi-SYM_ID_FIRST] = (sym_of(ts, gi) == TS2_ID);
    end
  endgenerate

  assign com_ok = (sym_of(ts, SYM_COM) == COM);

  always_comb begin
    ts_type = TS_NONE;
    if (com_ok && (&ts1_hit)) begin
      ts_type = TS_TYPE1;
    end else if (com_ok && (&ts2_hit)) begin
      ts_type = TS_TYPE2;
    end
  end

  assign well_formed = (ts_type != TS_NONE);
  assign link        = sym_of(ts, SYM_LINK);
  assign lane        = sym_of(ts, SYM_LANE);
  assign nfts        = sym_of(ts, SYM_NFTS);
  assign rate        = sym_of(ts, SYM_RATE);
  assign ctrl        = sym_of(ts, SYM_CTRL);

endmodule

// File: rtl/ts_rx_analyzer.sv
// Per-lane TS1/TS2 receive analyzer: counts consecutive identical TSs, reports
// captured fields to core_fsm and flags RX inactivity. Optional TSA_ERR_CNT_EN
// enables the saturating malformed-TS counter on err_cnt.
module ts_rx_analyzer
  import ts_rx_analyzer_pkg::*;
#(
  parameter int CONSEC_THRESH = 8,
  parameter int TIMEOUT_CYC   = 24000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [127:0] ts_i,
  input  logic         ts_i_vld,
  output logic         rpt_vld,
  input  logic         rpt_ack,
  output logic [1:0]   rpt_type,
  output logic [7:0]   rpt_link,
  output logic [7:0]   rpt_lane,
  output logic [7:0]   rpt_nfts,
  output logic [7:0]   rpt_rate,
  output logic [7:0]   rpt_ctrl,
  output logic         rpt_stale,
  output logic         rx_timeout,
  output logic [7:0]   err_cnt
);

  localparam int CNT_W = $clog2(CONSEC_THRESH + 1);
  localparam int TIM_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(CONSEC_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [TIM_W-1:0] TIM_MAX    = TIM_W'(TIMEOUT_CYC);
  localparam logic [1:0]       FIRST_STATE = (CONSEC_THRESH == 1) ? S_REPORT : S_TRACK;

  logic       dec_well;
  logic [1:0] dec_type;
  logic [7:0] dec_link, dec_lane, dec_nfts, dec_rate, dec_ctrl;
  ts_fields_t dec_fields;
  logic       identical;

  ts_decode u_decode (
    .ts          (ts_i),
    .well_formed (dec_well),
    .ts_type     (dec_type),
    .link        (dec_link),
    .lane        (dec_lane),
    .nfts        (dec_nfts),
    .rate        (dec_rate),
    .ctrl        (dec_ctrl)
  );

  assign dec_fields = {dec_type, dec_link, dec_lane, dec_nfts, dec_rate, dec_ctrl};

  logic [1:0]       state_reg, state_next, mid_state;
  logic [CNT_W-1:0] cnt_reg, cnt_next, mid_cnt;
  ts_fields_t       cap_reg, cap_next;
  logic             stale_reg, stale_next;
  logic [TIM_W-1:0] timer_reg;

  assign identical = dec_well && (dec_fields == cap_reg);

  // The ack is resolved first so a coincident TS is judged against the post-ack state.
  always_comb begin
    mid_state  = state_reg;
    mid_cnt    = cnt_reg;
    stale_next = stale_reg;
    if (state_reg == S_REPORT && rpt_ack) begin
      mid_state  = stale_reg ? S_IDLE : S_TRACK;
      mid_cnt    = '0;
      stale_next = 1'b0;
    end

    state_next = mid_state;
    cnt_next   = mid_cnt;
    cap_next   = cap_reg;
    if (ts_i_vld) begin
      case (mid_state)
        S_IDLE: begin
          if (dec_well) begin
            cap_next   = dec_fields;
            cnt_next   = CNT_ONE;
            state_next = FIRST_STATE;
          end
        end
        S_TRACK: begin
          if (!dec_well) begin
            cnt_next   = '0;
            state_next = S_IDLE;
          end else if (identical) begin
            cnt_next = mid_cnt + CNT_ONE;
            if (cnt_next == CNT_THRESH) begin
              state_next = S_REPORT;
            end
          end else begin
            cap_next   = dec_fields;
            cnt_next   = CNT_ONE;
            state_next = FIRST_STATE;
          end
        end
        S_REPORT: begin
          if (!identical) begin
            stale_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    if (clr) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      cap_next   = cap_reg;
      stale_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      cap_reg   <= '0;
      stale_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cap_reg   <= cap_next;
      stale_reg <= stale_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg <= '0;
    end else if (clr || ts_i_vld) begin
      timer_reg <= '0;
    end else if (timer_reg != TIM_MAX) begin
      timer_reg <= timer_reg + TIM_W'(1);
    end
  end

`ifdef TSA_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg <= 8'h00;
    end else if (ts_i_vld && !clr && !dec_well && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'h00;
`endif

  // Fields read as zero whenever no report is pending.
  assign rpt_vld    = (state_reg == S_REPORT);
  assign rpt_type   = rpt_vld ? cap_reg.ts_type : TS_NONE;
  assign rpt_link   = rpt_vld ? cap_reg.link : 8'h00;
  assign rpt_lane   = rpt_vld ? cap_reg.lane : 8'h00;
  assign rpt_nfts   = rpt_vld ? cap_reg.nfts : 8'h00;
  assign rpt_rate   = rpt_vld ? cap_reg.rate : 8'h00;
  assign rpt_ctrl   = rpt_vld ? cap_reg.ctrl : 8'h00;
  assign rpt_stale  = stale_reg;
  assign rx_timeout = (timer_reg == TIM_MAX);

endmodule

// File: tb/tb_ts_rx_analyzer.sv
// Self-checking bench for ts_rx_analyzer: a run-length reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ts_rx_analyzer;

  localparam int TH = 8;
  localparam int TO = 24000;
`ifdef TSA_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         clr;
  logic [127:0] ts_i;
  logic         ts_i_vld;
  logic         rpt_vld;
  logic         rpt_ack;
  logic [1:0]   rpt_type;
  logic [7:0]   rpt_link, rpt_lane, rpt_nfts, rpt_rate, rpt_ctrl;
  logic         rpt_stale;
  logic         rx_timeout;
  logic [7:0]   err_cnt;

  ts_rx_analyzer #(.CONSEC_THRESH(TH), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ts_i       (ts_i),
    .ts_i_vld   (ts_i_vld),
    .rpt_vld    (rpt_vld),
    .rpt_ack    (rpt_ack),
    .rpt_type   (rpt_type),
    .rpt_link   (rpt_link),
    .rpt_lane   (rpt_lane),
    .rpt_nfts   (rpt_nfts),
    .rpt_rate   (rpt_rate),
    .rpt_ctrl   (rpt_ctrl),
    .rpt_stale  (rpt_stale),
    .rx_timeout (rx_timeout),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a run of matching TSs since the last reference capture.
  bit         m_have, m_pend, m_stale;
  int         m_run, m_idle, m_err;
  int         m_kind;
  logic [7:0] m_f [1:5];

  function automatic int ts_kind(input logic [127:0] t);
    int n1 = 0;
    int n2 = 0;
    if (t[7:0] != 8'hBC) return 0;
    for (int k = 6; k < 16; k++) begin
      if (t[8*k +: 8] == 8'h4A) n1++;
      else if (t[8*k +: 8] == 8'h45) n2++;
    end
    if (n1 == 10) return 1;
    if (n2 == 10) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_have = 0; m_pend = 0; m_stale = 0;
    m_run = 0; m_idle = 0; m_err = 0; m_kind = 0;
    for (int k = 1; k <= 5; k++) m_f[k] = 8'h00;
  endtask

  task automatic model_step(input bit c, input bit a, input bit v, input logic [127:0] t);
    int  kind;
    bit  same;
    kind = ts_kind(t);
    if (c) begin
      m_have = 0; m_run = 0; m_pend = 0; m_stale = 0; m_idle = 0;
    end else begin
      if (a && m_pend) begin
        m_pend = 0;
        m_run  = 0;
        if (m_stale) begin
          m_have  = 0;
          m_stale = 0;
        end
      end
      if (!v) begin
        if (m_idle < TO) m_idle++;
      end else begin
        m_idle = 0;
        if (kind == 0 && ERR_EN && m_err < 255) m_err++;
        same = (kind != 0) && m_have && (kind == m_kind);
        for (int k = 1; k <= 5; k++) if (t[8*k +: 8] != m_f[k]) same = 0;
        if (m_pend) begin
          if (!same) m_stale = 1;
        end else if (kind == 0) begin
          m_have = 0;
          m_run  = 0;
        end else begin
          if (!same) begin
            m_have = 1;
            m_kind = kind;
            for (int k = 1; k <= 5; k++) m_f[k] = t[8*k +: 8];
            m_run = 0;
          end
          m_run++;
          if (m_run == TH) m_pend = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk("rpt_vld",    rpt_vld,    m_pend);
    chk("rpt_type",   rpt_type,   m_pend ? m_kind : 0);
    chk("rpt_link",   rpt_link,   m_pend ? m_f[1] : 8'h00);
    chk("rpt_lane",   rpt_lane,   m_pend ? m_f[2] : 8'h00);
    chk("rpt_nfts",   rpt_nfts,   m_pend ? m_f[3] : 8'h00);
    chk("rpt_rate",   rpt_rate,   m_pend ? m_f[4] : 8'h00);
    chk("rpt_ctrl",   rpt_ctrl,   m_pend ? m_f[5] : 8'h00);
    chk("rpt_stale",  rpt_stale,  m_stale);
    chk("rx_timeout", rx_timeout, m_idle == TO);
    chk("err_cnt",    err_cnt,    m_err);
  end

  function automatic logic [127:0] mk_ts(input logic [7:0] com, input logic [7:0] id,
                                         input logic [7:0] link, input logic [7:0] lane,
                                         input logic [7:0] nfts, input logic [7:0] rate,
                                         input logic [7:0] ctrl);
    logic [127:0] t;
    t = '0;
    t[7:0]   = com;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = nfts;
    t[39:32] = rate;
    t[47:40] = ctrl;
    for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
    return t;
  endfunction

  task automatic cycle(input bit c, input bit a, input bit v, input logic [127:0] t);
    clr = c; rpt_ack = a; ts_i_vld = v; ts_i = t;
    @(posedge clk);
    model_step(c, a, v, t);
    @(negedge clk);
    clr = 1'b0; rpt_ack = 1'b0; ts_i_vld = 1'b0;
    if (c || a || v)
      $display("txn t=%0t clr=%0d ack=%0d vld=%0d sym0=%02h lane=%02h -> rpt_vld=%0d type=%0d lane=%02h stale=%0d err=%0d",
               $time, c, a, v, t[7:0], t[23:16], rpt_vld, rpt_type, rpt_lane, rpt_stale, err_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [127:0] ts_a, ts_b, ts_c, ts_t2, ts_bad;

  initial begin
    ts_a   = mk_ts(8'hBC, 8'h4A, 8'h00, 8'h02, 8'h10, 8'h02, 8'h00);
    ts_b   = mk_ts(8'hBC, 8'h4A, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00);
    ts_c   = mk_ts(8'hBC, 8'h4A, 8'h01, 8'h05, 8'h20, 8'h04, 8'h08);
    ts_t2  = mk_ts(8'hBC, 8'h45, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00);
    ts_bad = mk_ts(8'h00, 8'h4A, 8'h01, 8'h05, 8'h20, 8'h04, 8'h08);
    model_reset();
    rst = 1'b0; clr = 1'b0; rpt_ack = 1'b0; ts_i_vld = 1'b0; ts_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_vld", rpt_vld, 0);
    chk("reset_timeout", rx_timeout, 0);
    chk("reset_err", err_cnt, 0);
    rst = 1'b1;

    // Stray ack while idle, then eight identical TS1s 64 cycles apart.
    cycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, ts_a);
      if (i == 7) chk("A_vld_before_8th", rpt_vld, 0);
      if (i == 8) begin
        chk("A_vld", rpt_vld, 1);
        chk("A_type", rpt_type, 1);
        chk("A_lane", rpt_lane, 2);
        chk("A_rate", rpt_rate, 2);
      end
      if (i < 8) idle(63);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("A_vld_after_ack", rpt_vld, 0);

    // Five more lane-2, then a lane change restarts the run.
    for (int i = 0; i < 5; i++) begin cycle(1'b0, 1'b0, 1'b1, ts_a); idle(1); end
    chk("B_vld_after_5", rpt_vld, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, ts_b);
      if (i < 8) chk("B_vld_early", rpt_vld, 0);
      else begin
        chk("B_vld", rpt_vld, 1);
        chk("B_lane", rpt_lane, 3);
      end
      idle(1);
    end
    cycle(1'b0, 1'b0, 1'b1, ts_b);
    chk("B_identical_not_stale", rpt_stale, 0);

    // A TS2 while a report is pending marks it stale; ack drops to idle.
    cycle(1'b0, 1'b0, 1'b1, ts_t2);
    chk("C_stale", rpt_stale, 1);
    chk("C_vld_held", rpt_vld, 1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("C_vld_after_ack", rpt_vld, 0);
    chk("C_stale_after_ack", rpt_stale, 0);

    // Ack coincident with an identical TS: the TS counts as first of the next run.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ts_b);
    chk("C2_vld", rpt_vld, 1);
    cycle(1'b0, 1'b1, 1'b1, ts_b);
    chk("C2_vld_ack_ts", rpt_vld, 0);
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b0, 1'b0, 1'b1, ts_b);
      if (i == 6) chk("C2_vld_run7", rpt_vld, 0);
      if (i == 7) chk("C2_vld_run8", rpt_vld, 1);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Malformed TS mid-count restarts the run.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, ts_c);
    cycle(1'b0, 1'b0, 1'b1, ts_bad);
    chk("D_err", err_cnt, ERR_EN ? 1 : 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, ts_c);
      if (i == 7) chk("D_vld_run7", rpt_vld, 0);
      if (i == 8) begin
        chk("D_vld_run8", rpt_vld, 1);
        chk("D_link", rpt_link, 1);
        chk("D_ctrl", rpt_ctrl, 8'h08);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, '0);

    // clr during a pending report, with a TS in the same cycle that must be dropped.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ts_c);
    chk("E_vld", rpt_vld, 1);
    cycle(1'b1, 1'b0, 1'b1, ts_a);
    chk("E_vld_after_clr", rpt_vld, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, ts_a);
      if (i == 7) chk("E_vld_run7", rpt_vld, 0);
      if (i == 8) chk("E_vld_run8", rpt_vld, 1);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Inactivity timeout.
    cycle(1'b0, 1'b0, 1'b1, ts_a);
    idle(TO - 1);
    chk("F_timeout_early", rx_timeout, 0);
    idle(1);
    chk("F_timeout", rx_timeout, 1);
    cycle(1'b0, 1'b0, 1'b1, ts_a);
    chk("F_timeout_clear", rx_timeout, 0);

    // Asynchronous reset during a pending report.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ts_a);
    chk("G_vld", rpt_vld, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("G_vld_async", rpt_vld, 0);
    chk("G_err_async", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
